pkt_ff_ingress_chk: RTL and testbench
=====================================

Name: pkt_ff_ingress_chk

Overview:
- Framing checker and write-side gate placed directly upstream of the packet FIFO write-pointer stage.
- Accepts a raw packet stream (valid/sop/eop/error) and emits a cleaned valid/sop/eop/error stream to the write-pointer stage.
- Any packet that is malformed, too long, upstream-errored or hits FIFO full is converted into a single error cycle, so the write pointer rewinds to the packet's SOP location.
- The rest of the offending packet is discarded and counted.

Parameters:
- MAX_PKT_LEN, 256: max words per packet, sop and eop words inclusive.
- LEN_W, 9: packet length counter width; must hold MAX_PKT_LEN.
- MIN_PKT_LEN, 2: min words per packet; used only with the optional feature.
- CNT_W, 16: width of the drop statistics counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  upstream word valid
- in_sop  in  1  start of packet
- in_eop  in  1  end of packet
- in_error  in  1  upstream error flag, qualified by in_valid
- ff_full  in  1  FIFO full from the write-pointer domain
- out_valid  out  1  word/command valid to the write-pointer stage
- out_sop  out  1  start of packet
- out_eop  out  1  end of packet
- out_error  out  1  rewind command; qualified by out_valid
- orphan_pls  out  1  one-cycle pulse: word received outside a packet
- drop_cnt  out  CNT_W  saturating count of aborted/dropped packets

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Latency: all outputs are registered; exactly one cycle from input to output. There is no backpressure to upstream.
- Reset values: out_* = 0, orphan_pls = 0, drop_cnt = 0, len = 0, state = IDLE.
- Abort cycle: out_valid=1, out_error=1, out_sop=0, out_eop=0. Every abort increments drop_cnt by 1, saturating at all-ones.
- Normal word: out_valid=1 with out_sop/out_eop copied from the input and out_error=0.
- FSM states: IDLE, PKT, DROP.
- IDLE:
  - in_valid&~in_sop: word discarded, orphan_pls=1, stay IDLE.
  - in_valid&in_sop&ff_full: nothing written, drop_cnt+1, go to DROP; if in_eop also set, stay IDLE.
  - in_valid&in_sop&in_error: nothing written, drop_cnt+1, go to DROP (or IDLE if in_eop).
  - in_valid&in_sop otherwise: emit normal word, len=1. Go to PKT; if in_eop, stay IDLE (single-word packet).
- PKT, checks in priority order when in_valid=1:
  1. in_sop (missing eop): abort cycle, new sop word discarded, go to DROP. If in_eop is also set, go to IDLE.
  2. in_error or ff_full: abort cycle; go to IDLE if in_eop, else DROP.
  3. len==MAX_PKT_LEN (word would exceed the limit): abort cycle; go to IDLE if in_eop, else DROP.
  4. Otherwise: emit normal word, len+1. On in_eop, go to IDLE and clear len.
- DROP: discard all words, outputs idle. Leave to IDLE only on in_valid&in_eop; in_sop is ignored.
- in_valid=0: no output, no state or counter change.
- Length arithmetic: len is unsigned LEN_W wide and never wraps, because it is bounded by the MAX_PKT_LEN check.
- Reset mid-packet: state returns to IDLE and no abort cycle is emitted. The downstream pointer is reset by the same system reset.

Optional Feature:
- Macro: PKT_FF_INGRESS_MIN_LEN_EN.
- Defined: in PKT, an in_eop word that arrives with len+1 < MIN_PKT_LEN produces an abort cycle instead of the eop word, then the FSM goes to IDLE with drop_cnt+1. A single-word sop&eop packet in IDLE is dropped (no output, drop_cnt+1) when MIN_PKT_LEN > 1.
- Undefined: no minimum-length check; MIN_PKT_LEN is unused.

Decomposition:
- Shared package pkt_ff_pkg holds:
  - the state encoding (IDLE=2'd0, PKT=2'd1, DROP=2'd2);
  - the abort-cycle field constants;
  - default widths for PTR_W/LEN_W/CNT_W, shared with the pointer stages.
- One natural sub-module: pkt_ff_sat_cntr, a parameterised saturating counter with inc enable and synchronous clear, used for drop_cnt.

Test Plan:
- 4-word packet (sop w0, w1, w2, eop w3) with ff_full=0 -> 4 out_valid cycles, each 1 cycle later; out_sop on the first, out_eop on the last; drop_cnt=0.
- sop, w1, then in_sop again on the 3rd word -> 3rd output cycle is out_valid=1/out_error=1; the following words are discarded until eop; drop_cnt=1; FSM back in IDLE.
- MAX_PKT_LEN=4, 6-word packet -> 4 normal outputs, 5th word gives an abort cycle, 6th (eop) is discarded; drop_cnt=1.
- ff_full asserted on word 2 of a 5-word packet -> abort at word 2, words 3-5 silent; next packet is accepted normally.
- Word without sop while IDLE -> orphan_pls=1 for one cycle, no out_valid. drop_cnt preset near saturation (CNT_W=2, 4 aborts) -> holds at 3.
- With PKT_FF_INGRESS_MIN_LEN_EN and MIN_PKT_LEN=3, 2-word packet -> sop output, then an abort cycle in place of the eop word; drop_cnt=1.

Source files
------------

// File: rtl/pkt_ff_pkg.sv
// rtl/pkt_ff_pkg.sv - shared state encoding, word fields and default widths for the packet FIFO stages
package pkt_ff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam int PTR_W_DEF = 8;
  localparam int LEN_W_DEF = 9;
  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic valid;
    logic sop;
    logic eop;
    logic error;
  } word_t;

  // Abort cycle: the write-pointer stage rewinds to the SOP location of the packet.
  localparam word_t ABORT_WORD = '{valid: 1'b1, sop: 1'b0, eop: 1'b0, error: 1'b1};
  localparam word_t IDLE_WORD  = '{valid: 1'b0, sop: 1'b0, eop: 1'b0, error: 1'b0};

  function automatic word_t norm_word(input logic sop, input logic eop);
    return '{valid: 1'b1, sop: sop, eop: eop, error: 1'b0};
  endfunction

endpackage

// File: rtl/pkt_ff_ingress_chk_if.sv
// rtl/pkt_ff_ingress_chk_if.sv - valid/sop/eop/error packet word stream
interface pkt_ff_ingress_chk_if;
  logic valid;
  logic sop;
  logic eop;
  logic error;

  modport master (output valid, sop, eop, error);
  modport slave  (input  valid, sop, eop, error);
endinterface

// File: rtl/pkt_ff_sat_cntr.sv
// rtl/pkt_ff_sat_cntr.sv - saturating up-counter with increment enable and synchronous clear
module pkt_ff_sat_cntr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pkt_ff_ingress_chk.sv
// rtl/pkt_ff_ingress_chk.sv - framing checker gating writes into the packet FIFO write-pointer stage
// Optional minimum-length check: define PKT_FF_INGRESS_MIN_LEN_EN.
module pkt_ff_ingress_chk
  import pkt_ff_pkg::*;
#(
  parameter int MAX_PKT_LEN = 256,
  parameter int LEN_W       = LEN_W_DEF,
  parameter int MIN_PKT_LEN = 2,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  pkt_ff_ingress_chk_if.slave  in_if,
  input  logic                 ff_full,
  pkt_ff_ingress_chk_if.master out_if,
  output logic                 orphan_pls,
  output logic [CNT_W-1:0]     drop_cnt
);

  if (MAX_PKT_LEN >= (1 << LEN_W)) begin : g_len_w_chk
    $error("LEN_W cannot hold MAX_PKT_LEN");
  end
  if ((MIN_PKT_LEN < 1) || (MIN_PKT_LEN > MAX_PKT_LEN)) begin : g_min_len_chk
    $error("MIN_PKT_LEN out of range");
  end

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_PKT_LEN);
`ifdef PKT_FF_INGRESS_MIN_LEN_EN
  localparam logic [LEN_W:0] MIN_LEN_C       = (LEN_W+1)'(MIN_PKT_LEN);
  localparam bit             MIN_SINGLE_DROP = (MIN_PKT_LEN > 1);
`else
  localparam bit             MIN_SINGLE_DROP = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  word_t            out_q, out_d;
  logic             orphan_q, orphan_d;
  logic             drop_inc;
  logic             short_eop;
  logic             pkt_abort;

  always_comb begin
    short_eop = 1'b0;
`ifdef PKT_FF_INGRESS_MIN_LEN_EN
    short_eop = in_if.eop && (({1'b0, len_q} + (LEN_W+1)'(1)) < MIN_LEN_C);
`endif
    pkt_abort = in_if.sop || in_if.error || ff_full || (len_q == LEN_MAX) || short_eop;
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    out_d    = IDLE_WORD;
    orphan_d = 1'b0;
    drop_inc = 1'b0;
    if (in_if.valid) begin
      case (state_q)
        ST_IDLE: begin
          if (!in_if.sop) begin
            orphan_d = 1'b1;
          end else if (in_if.error || ff_full || (in_if.eop && MIN_SINGLE_DROP)) begin
            // Nothing was written yet, so there is nothing to rewind.
            drop_inc = 1'b1;
            state_d  = in_if.eop ? ST_IDLE : ST_DROP;
          end else begin
            out_d   = norm_word(1'b1, in_if.eop);
            len_d   = in_if.eop ? '0 : LEN_W'(1);
            state_d = in_if.eop ? ST_IDLE : ST_PKT;
          end
        end
        ST_PKT: begin
          if (pkt_abort) begin
            out_d    = ABORT_WORD;
            drop_inc = 1'b1;
            len_d    = '0;
            state_d  = in_if.eop ? ST_IDLE : ST_DROP;
          end else begin
            out_d   = norm_word(1'b0, in_if.eop);
            len_d   = in_if.eop ? '0 : (len_q + LEN_W'(1));
            state_d = in_if.eop ? ST_IDLE : ST_PKT;
          end
        end
        ST_DROP: begin
          if (in_if.eop) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          len_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      out_q    <= IDLE_WORD;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      out_q    <= out_d;
      orphan_q <= orphan_d;
    end
  end

  pkt_ff_sat_cntr #(.W(CNT_W)) u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (drop_inc),
    .cnt (drop_cnt)
  );

  assign out_if.valid = out_q.valid;
  assign out_if.sop   = out_q.sop;
  assign out_if.eop   = out_q.eop;
  assign out_if.error = out_q.error;
  assign orphan_pls   = orphan_q;

endmodule

// File: tb/tb_pkt_ff_ingress_chk.sv
// tb/tb_pkt_ff_ingress_chk.sv - directed vector bench for pkt_ff_ingress_chk (MAX_PKT_LEN=4, CNT_W=2, MIN_PKT_LEN=3)
module tb_pkt_ff_ingress_chk;

`ifdef PKT_FF_INGRESS_MIN_LEN_EN
  localparam bit MIN_EN = 1'b1;
`else
  localparam bit MIN_EN = 1'b0;
`endif

  // Expected output bits: {valid, sop, eop, error, orphan}
  localparam logic [4:0] O_NONE = 5'b00000;
  localparam logic [4:0] O_SOP  = 5'b11000;
  localparam logic [4:0] O_MID  = 5'b10000;
  localparam logic [4:0] O_EOP  = 5'b10100;
  localparam logic [4:0] O_ABT  = 5'b10010;
  localparam logic [4:0] O_ORP  = 5'b00001;

  typedef struct {
    logic       rst;
    logic       v;
    logic       s;
    logic       e;
    logic       err;
    logic       full;
    logic [4:0] exp;
    logic [1:0] cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ff_full = 1'b0;
  logic       orphan_pls;
  logic [1:0] drop_cnt;
  int         n_chk = 0;
  int         n_fail = 0;
  vec_t       vq[$];

  pkt_ff_ingress_chk_if in_if ();
  pkt_ff_ingress_chk_if out_if ();

  pkt_ff_ingress_chk #(
    .MAX_PKT_LEN (4),
    .LEN_W       (3),
    .MIN_PKT_LEN (3),
    .CNT_W       (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_if      (in_if),
    .ff_full    (ff_full),
    .out_if     (out_if),
    .orphan_pls (orphan_pls),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic v, input logic s, input logic e,
                     input logic err, input logic full, input logic [4:0] ex, input logic [1:0] c);
    vec_t t;
    t.rst = r; t.v = v; t.s = s; t.e = e; t.err = err; t.full = full; t.exp = ex; t.cnt = c;
    vq.push_back(t);
  endtask

  task automatic step(input logic r, input logic v, input logic s, input logic e,
                      input logic err, input logic full);
    @(negedge clk);
    rst = r; in_if.valid = v; in_if.sop = s; in_if.eop = e; in_if.error = err; ff_full = full;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [4:0] ex, input logic [1:0] c);
    logic [4:0] got;
    got = {out_if.valid, out_if.sop, out_if.eop, out_if.error, orphan_pls};
    n_chk++;
    if ((got !== ex) || (drop_cnt !== c)) begin
      n_fail++;
      $display("FAIL %s: got vsee_o=%b drop_cnt=%0d, expected vsee_o=%b drop_cnt=%0d",
               nm, got, drop_cnt, ex, c);
    end
  endtask

  initial begin
    in_if.valid = 1'b0; in_if.sop = 1'b0; in_if.eop = 1'b0; in_if.error = 1'b0;

    // reset state
    add(1, 0, 0, 0, 0, 0, O_NONE, 0);
    // 4-word packet with an idle gap carrying a stray sop
    add(0, 1, 1, 0, 0, 0, O_SOP, 0);
    add(0, 1, 0, 0, 0, 0, O_MID, 0);
    add(0, 0, 1, 0, 0, 0, O_NONE, 0);
    add(0, 1, 0, 0, 0, 0, O_MID, 0);
    add(0, 1, 0, 1, 0, 0, O_EOP, 0);
    add(0, 0, 0, 0, 0, 0, O_NONE, 0);
    // sop again on word 3: abort, then DROP ignores sop until eop
    add(0, 1, 1, 0, 0, 0, O_SOP, 0);
    add(0, 1, 0, 0, 0, 0, O_MID, 0);
    add(0, 1, 1, 0, 0, 0, O_ABT, 1);
    add(0, 1, 1, 0, 0, 0, O_NONE, 1);
    add(0, 1, 0, 1, 0, 0, O_NONE, 1);
    add(0, 1, 0, 0, 0, 0, O_ORP, 1);
    // 6-word packet over MAX_PKT_LEN=4
    add(1, 0, 0, 0, 0, 0, O_NONE, 0);
    add(0, 1, 1, 0, 0, 0, O_SOP, 0);
    add(0, 1, 0, 0, 0, 0, O_MID, 0);
    add(0, 1, 0, 0, 0, 0, O_MID, 0);
    add(0, 1, 0, 0, 0, 0, O_MID, 0);
    add(0, 1, 0, 0, 0, 0, O_ABT, 1);
    add(0, 1, 0, 1, 0, 0, O_NONE, 1);
    // ff_full on word 2 of 5, then a clean 3-word packet
    add(1, 0, 0, 0, 0, 0, O_NONE, 0);
    add(0, 1, 1, 0, 0, 0, O_SOP, 0);
    add(0, 1, 0, 0, 0, 1, O_ABT, 1);
    add(0, 1, 0, 0, 0, 0, O_NONE, 1);
    add(0, 1, 0, 0, 0, 1, O_NONE, 1);
    add(0, 1, 0, 1, 0, 0, O_NONE, 1);
    add(0, 1, 1, 0, 0, 0, O_SOP, 1);
    add(0, 1, 0, 0, 0, 0, O_MID, 1);
    add(0, 1, 0, 1, 0, 0, O_EOP, 1);
    // upstream error with eop inside a packet returns straight to IDLE
    add(1, 0, 0, 0, 0, 0, O_NONE, 0);
    add(0, 1, 1, 0, 0, 0, O_SOP, 0);
    add(0, 1, 0, 1, 1, 0, O_ABT, 1);
    add(0, 1, 0, 0, 0, 0, O_ORP, 1);
    add(0, 0, 0, 0, 0, 0, O_NONE, 1);
    // IDLE drops on sop with error/full; counter saturates at 3
    add(1, 0, 0, 0, 0, 0, O_NONE, 0);
    add(0, 1, 1, 1, 1, 0, O_NONE, 1);
    add(0, 1, 1, 1, 1, 0, O_NONE, 2);
    add(0, 1, 1, 1, 0, 1, O_NONE, 3);
    add(0, 1, 1, 1, 0, 1, O_NONE, 3);
    add(0, 1, 1, 0, 0, 0, O_SOP, 3);
    add(0, 1, 0, 1, 1, 0, O_ABT, 3);
    // 2-word and 1-word packets against MIN_PKT_LEN=3
    add(1, 0, 0, 0, 0, 0, O_NONE, 0);
    add(0, 1, 1, 0, 0, 0, O_SOP, 0);
    add(0, 1, 0, 1, 0, 0, MIN_EN ? O_ABT : O_EOP, MIN_EN ? 2'd1 : 2'd0);
    add(0, 1, 1, 1, 0, 0, MIN_EN ? O_NONE : 5'b11100, MIN_EN ? 2'd2 : 2'd0);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].v, vq[i].s, vq[i].e, vq[i].err, vq[i].full);
      check($sformatf("vec%0d", i), vq[i].exp, vq[i].cnt);
    end

    // Reset mid-packet: no abort cycle, FSM back in IDLE
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0); check("rstmid_sop", O_SOP, 0);
    step(0, 1, 0, 0, 0, 0); check("rstmid_w1", O_MID, 0);
    step(1, 1, 0, 0, 0, 0); check("rstmid_rst", O_NONE, 0);
    step(0, 1, 0, 0, 0, 0); check("rstmid_orphan", O_ORP, 0);
    step(0, 0, 0, 0, 0, 0); check("rstmid_pulse_end", O_NONE, 0);

    // Exactly MAX_PKT_LEN words, then back-to-back sop
    step(0, 1, 1, 0, 0, 0); check("max_sop", O_SOP, 0);
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 0, 0, 0, 0); check($sformatf("max_w%0d", k + 1), O_MID, 0);
    end
    step(0, 1, 0, 1, 0, 0); check("max_eop", O_EOP, 0);
    step(0, 1, 1, 0, 0, 0); check("b2b_sop", O_SOP, 0);
    step(0, 1, 0, 0, 0, 0); check("b2b_w1", O_MID, 0);
    step(0, 1, 1, 1, 0, 0); check("b2b_sop_eop_abort", O_ABT, 1);
    step(0, 1, 0, 0, 0, 0); check("b2b_idle_after", O_ORP, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
